// File: rtl/idct8x8_2d_pipe_block.sv
// ---------------------------------------------------------------------------
// idct8x8_2d_pipe_block
//
// Purpose:
//   Inverse 2-D 8x8 DCT. A whole 64-coefficient block is captured, an 8-point
//   1-D IDCT is run over the 8 columns (one column per cycle) and then over
//   the 8 rows (one row per cycle) through a single shared combinational
//   1-D datapath. The reconstructed 64-sample block is then presented on
//   out_block until downstream accepts it.
//   Arithmetic is Q8 fixed point: every product is computed at
//   IN_W+CONST_W bits, arithmetically shifted right by FRAC (truncation
//   towards minus infinity) and cut back to IN_W bits. Sums wrap.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        in_block holds a valid coefficient block
//   in_block   in   64*IN_W  X[r][c] at [(r*8+c)*IN_W +: IN_W]
//   in_ready   out  1        core is idle and can accept a block
//   out_valid  out  1        out_block holds a reconstructed block
//   out_block  out  64*IN_W  x[r][c] at [(r*8+c)*IN_W +: IN_W]
//   out_ready  in   1        downstream consumes the block
//
// Timing: out_valid rises 16 cycles after the accepting edge; with
// out_ready tied high a new block can be accepted every 18 cycles.
// ---------------------------------------------------------------------------
module idct8x8_2d_pipe_block #(
    parameter int IN_W    = 32,
    parameter int FRAC    = 8,
    parameter int CONST_W = 10,
    parameter int CLAMP   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [64*IN_W-1:0]   in_block,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [64*IN_W-1:0]   out_block,
    input  logic                 out_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COL  = 2'd1;
    localparam logic [1:0] S_ROW  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam int PROD_W = IN_W + CONST_W;

    localparam logic signed [IN_W-1:0] SAT_HI = IN_W'(127);
    localparam logic signed [IN_W-1:0] SAT_LO = -IN_W'(128);

    // -----------------------------------------------------------------------
    // Basis constant T[k][n] = sign * M[fold(k*(2n+1))].
    // The angle index k*(2n+1) is reduced modulo 32 (cos period is 2*pi),
    // mirrored about 16 (cos is even), then mirrored about 8 with a sign
    // flip (cos(pi - x) = -cos(x)). The DC row uses 91 (~128/sqrt(2)).
    // Called only with loop constants, so it folds to fixed coefficients.
    // -----------------------------------------------------------------------
    function automatic logic signed [CONST_W-1:0] basis(input int k, input int n);
        int                          m;
        int                          mag;
        logic                        neg;
        logic signed [CONST_W-1:0]   t;
        neg = 1'b0;
        mag = 0;
        if (k == 0) begin
            mag = 91;
        end else begin
            m = (k * (2 * n + 1)) % 32;
            if (m > 16) m = 32 - m;
            if (m > 8) begin
                m   = 16 - m;
                neg = 1'b1;
            end
            case (m)
                1:       mag = 126;
                2:       mag = 118;
                3:       mag = 106;
                4:       mag = 91;
                5:       mag = 71;
                6:       mag = 49;
                7:       mag = 25;
                default: mag = 0;
            endcase
        end
        t = CONST_W'(mag);
        if (neg) t = -t;
        return t;
    endfunction

    // Q8 product: full-width signed multiply, arithmetic shift, truncate.
    function automatic logic signed [IN_W-1:0] mul(input logic signed [IN_W-1:0]    a,
                                                   input logic signed [CONST_W-1:0] b);
        logic signed [PROD_W-1:0] ae;
        logic signed [PROD_W-1:0] be;
        logic signed [PROD_W-1:0] p;
        logic signed [PROD_W-1:0] s;
        ae = {{CONST_W{a[IN_W-1]}}, a};
        be = {{IN_W{b[CONST_W-1]}}, b};
        p  = ae * be;
        s  = p >>> FRAC;
        return $signed(s[IN_W-1:0]);
    endfunction

    // Saturate to the 8-bit sample range.
    function automatic logic signed [IN_W-1:0] sat8(input logic signed [IN_W-1:0] x);
        logic signed [IN_W-1:0] y;
        y = x;
        if (x > SAT_HI) y = SAT_HI;
        if (x < SAT_LO) y = SAT_LO;
        return y;
    endfunction

    logic [1:0]              r_state;
    logic [2:0]              r_cnt;
    logic signed [IN_W-1:0]  r_coef_mem [64];
    logic signed [IN_W-1:0]  r_tmp_mem  [64];
    logic signed [IN_W-1:0]  r_res_mem  [64];

    logic signed [IN_W-1:0]  w_vec_in   [8];
    logic signed [IN_W-1:0]  w_vec_out  [8];
    logic signed [IN_W-1:0]  w_row_res  [8];

    // --- stage: operand select for the shared 1-D IDCT ---------------------
    // Column pass reads column r_cnt of the coefficients (index k*8+c);
    // row pass reads row r_cnt of the intermediate (index r*8+k). The
    // {hi,lo} concatenation is the row-major address r*8+c.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_vec_in[k] = '0;
            if (r_state == S_ROW) begin
                w_vec_in[k] = r_tmp_mem[{r_cnt, 3'(k)}];
            end else begin
                w_vec_in[k] = r_coef_mem[{3'(k), r_cnt}];
            end
        end
    end

    // --- stage: 8-point direct-form 1-D IDCT --------------------------------
    always_comb begin
        logic signed [IN_W-1:0] acc;
        acc = '0;
        for (int n = 0; n < 8; n++) begin
            acc = '0;
            for (int k = 0; k < 8; k++) begin
                acc = acc + mul(w_vec_in[k], basis(k, n));
            end
            w_vec_out[n] = acc;
            // Only the final row-pass result is ever saturated.
            w_row_res[n] = (CLAMP != 0) ? sat8(acc) : acc;
        end
    end

    // --- stage: control FSM and block memories -----------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            for (int i = 0; i < 64; i++) begin
                r_coef_mem[i] <= '0;
                r_tmp_mem[i]  <= '0;
                r_res_mem[i]  <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 64; i++) begin
                            r_coef_mem[i] <= in_block[i*IN_W +: IN_W];
                        end
                        r_cnt   <= 3'd0;
                        r_state <= S_COL;
                    end
                end
                S_COL: begin
                    // Column c result n lands at intermediate row n, column c.
                    for (int n = 0; n < 8; n++) begin
                        r_tmp_mem[{3'(n), r_cnt}] <= w_vec_out[n];
                    end
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_cnt   <= 3'd0;
                        r_state <= S_ROW;
                    end
                end
                S_ROW: begin
                    for (int n = 0; n < 8; n++) begin
                        r_res_mem[{r_cnt, 3'(n)}] <= w_row_res[n];
                    end
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_cnt   <= 3'd0;
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

    // --- stage: output decode ----------------------------------------------
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);

    // The result memory drives the output directly, so the last block stays
    // visible after the handshake until the next row pass overwrites it.
    always_comb begin
        out_block = '0;
        for (int i = 0; i < 64; i++) begin
            out_block[i*IN_W +: IN_W] = r_res_mem[i];
        end
    end

endmodule

// File: tb/tb_idct8x8_2d_pipe_block.sv
module tb_idct8x8_2d_pipe_block;

    localparam int IN_W = 32;
    localparam int NV   = 9;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                in_valid  = 1'b0;
    logic                out_ready = 1'b1;
    logic [64*IN_W-1:0]  in_block  = '0;

    logic                in_ready,   out_valid;
    logic [64*IN_W-1:0]  out_block;
    logic                in_ready_c, out_valid_c;
    logic [64*IN_W-1:0]  out_block_c;

    always #5 clk = ~clk;

    idct8x8_2d_pipe_block #(.IN_W(IN_W), .FRAC(8), .CONST_W(10), .CLAMP(0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_block  (in_block),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_block (out_block),
        .out_ready (out_ready)
    );

    idct8x8_2d_pipe_block #(.IN_W(IN_W), .FRAC(8), .CONST_W(10), .CLAMP(1)) u_dut_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_block  (in_block),
        .in_ready  (in_ready_c),
        .out_valid (out_valid_c),
        .out_block (out_block_c),
        .out_ready (out_ready)
    );

    // Up to two nonzero coefficients; expected row pattern pat[] (CLAMP=0)
    // and patc[] (CLAMP=1). When vert=1 the pattern runs down the rows
    // (x[r][n] = pat[r]), otherwise along each row (x[r][n] = pat[n]).
    typedef struct {
        int r0; int c0; int v0;
        int r1; int c1; int v1;
        int vert;
        int pat[8];
        int patc[8];
    } vec_t;

    vec_t  vecs  [NV];
    string vname [NV];
    int    checks = 0;
    int    errors = 0;

    task automatic set_in(input int i, input string nm, input int r0, input int c0, input int v0,
                          input int r1, input int c1, input int v1, input int vert);
        vname[i]     = nm;
        vecs[i].r0   = r0; vecs[i].c0 = c0; vecs[i].v0 = v0;
        vecs[i].r1   = r1; vecs[i].c1 = c1; vecs[i].v1 = v1;
        vecs[i].vert = vert;
    endtask

    function automatic int exp_val(input int idx, input int i, input bit clamp);
        int sel;
        sel = (vecs[idx].vert != 0) ? (i / 8) : (i % 8);
        return clamp ? vecs[idx].patc[sel] : vecs[idx].pat[sel];
    endfunction

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_block(input string name, input int idx);
        int bad;
        int bi;
        int bg;
        int be;
        int got;
        for (int d = 0; d < 2; d++) begin
            bad = 0; bi = 0; bg = 0; be = 0;
            for (int i = 0; i < 64; i++) begin
                got = (d == 0) ? $signed(out_block[i*IN_W +: IN_W])
                               : $signed(out_block_c[i*IN_W +: IN_W]);
                if (got != exp_val(idx, i, d[0]) && bad == 0) begin
                    bad = 1; bi = i; bg = got; be = exp_val(idx, i, d[0]);
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s block (clamp=%0d) x[%0d][%0d]: got %0d, expected %0d",
                         name, d, bi / 8, bi % 8, bg, be);
            end
        end
    endtask

    task automatic load_block(input int idx);
        in_block = '0;
        in_block[(vecs[idx].r0*8 + vecs[idx].c0)*IN_W +: IN_W] = vecs[idx].v0;
        if (vecs[idx].v1 != 0)
            in_block[(vecs[idx].r1*8 + vecs[idx].c1)*IN_W +: IN_W] = vecs[idx].v1;
    endtask

    // Present a block and hold in_valid for exactly the accepting edge.
    task automatic send(input int idx);
        int w;
        load_block(idx);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq({vname[idx], " in_ready before accept"}, int'(in_ready), 1);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid, bounded.
    task automatic wait_out(input string name);
        int cycles;
        int busy;
        cycles = 0;
        busy   = 0;
        while (!out_valid && cycles < 40) begin
            if (in_ready || in_ready_c) busy = 1;
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        check_eq({name, " latency"}, cycles, 16);
        check_eq({name, " in_ready low while busy"}, busy, 0);
        check_eq({name, " in_ready with out_valid"}, int'(in_ready & out_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp_bad;

        set_in(0, "zero",      0, 0,     0, 0, 0,   0, 0);
        vecs[0].pat  = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[0].patc = '{0, 0, 0, 0, 0, 0, 0, 0};
        set_in(1, "dc_pos",    0, 0,   800, 0, 0,   0, 0);
        vecs[1].pat  = '{100, 100, 100, 100, 100, 100, 100, 100};
        vecs[1].patc = '{100, 100, 100, 100, 100, 100, 100, 100};
        set_in(2, "dc_neg",    0, 0,  -800, 0, 0,   0, 0);
        vecs[2].pat  = '{-102, -102, -102, -102, -102, -102, -102, -102};
        vecs[2].patc = '{-102, -102, -102, -102, -102, -102, -102, -102};
        set_in(3, "ac01_pos",  0, 1,   256, 0, 0,   0, 0);
        vecs[3].pat  = '{44, 37, 25, 8, -9, -26, -38, -45};
        vecs[3].patc = '{44, 37, 25, 8, -9, -26, -38, -45};
        set_in(4, "ac01_neg",  0, 1,  -256, 0, 0,   0, 0);
        vecs[4].pat  = '{-45, -38, -26, -9, 8, 25, 37, 44};
        vecs[4].patc = '{-45, -38, -26, -9, 8, 25, 37, 44};
        set_in(5, "ac10_vert", 1, 0,   256, 0, 0,   0, 1);
        vecs[5].pat  = '{44, 37, 25, 8, -9, -26, -38, -45};
        vecs[5].patc = '{44, 37, 25, 8, -9, -26, -38, -45};
        set_in(6, "dc_clamp_hi", 0, 0, 2048, 0, 0,  0, 0);
        vecs[6].pat  = '{258, 258, 258, 258, 258, 258, 258, 258};
        vecs[6].patc = '{127, 127, 127, 127, 127, 127, 127, 127};
        set_in(7, "dc_plus_ac", 0, 0,  800, 0, 1, 256, 0);
        vecs[7].pat  = '{144, 137, 125, 108, 91, 74, 62, 55};
        vecs[7].patc = '{127, 127, 125, 108, 91, 74, 62, 55};
        set_in(8, "dc_clamp_lo", 0, 0, -2048, 0, 0, 0, 0);
        vecs[8].pat  = '{-259, -259, -259, -259, -259, -259, -259, -259};
        vecs[8].patc = '{-128, -128, -128, -128, -128, -128, -128, -128};

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("reset out_valid", int'(out_valid), 0);
        check_eq("reset in_ready", int'(in_ready), 1);
        check_block("reset", 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven blocks with out_ready held high.
        for (int v = 0; v < NV; v++) begin
            send(v);
            wait_out(vname[v]);
            check_block(vname[v], v);
            @(posedge clk);
            @(negedge clk);
            check_eq({vname[v], " idle in_ready"}, int'(in_ready), 1);
            check_eq({vname[v], " idle out_valid"}, int'(out_valid), 0);
        end

        // Backpressure: result held while a new block waits on in_valid.
        out_ready = 1'b0;
        send(1);
        wait_out("bp_first");
        check_block("bp_first", 1);
        load_block(3);
        in_valid = 1'b1;
        bp_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || in_ready) bp_bad = 1;
            for (int j = 0; j < 64; j++)
                if ($signed(out_block[j*IN_W +: IN_W]) != exp_val(1, j, 1'b0)) bp_bad = 1;
        end
        check_eq("bp hold valid/ready/data", bp_bad, 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp release in_ready", int'(in_ready), 1);
        check_eq("bp release out_valid", int'(out_valid), 0);
        check_block("bp held after handshake", 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out("bp_second");
        check_block("bp_second", 3);
        @(posedge clk);
        @(negedge clk);

        // Reset during the 4th row-pass cycle.
        send(7);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrow reset out_valid", int'(out_valid), 0);
        check_eq("midrow reset in_ready", int'(in_ready), 1);
        check_block("midrow reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0);
        wait_out("after_reset_zero");
        check_block("after_reset_zero", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idct8x8_2d_pipe_block.md
Name: idct8x8_2d_pipe_block

Overview:
Inverse 2-D 8x8 DCT, the decode-side counterpart of the forward 8x8 DCT core. It accepts a whole 64-coefficient block, runs an 8-point 1-D IDCT over the 8 columns and then over the 8 rows, and emits a whole 64-sample block. A single time-multiplexed 1-D IDCT datapath is used, with the same Q8 fixed-point, truncating arithmetic and block-granularity ready/valid handshake as the forward core.

Parameters:
IN_W, 32, width of every coefficient, intermediate and output sample (signed two's complement)
FRAC, 8, fractional bits of the constants; every product is arithmetically shifted right by FRAC
CONST_W, 10, signed width of the basis constants
CLAMP, 0, when 1 the final outputs saturate to [-128,127]; when 0 they wrap to IN_W bits

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_block holds a valid coefficient block
in_block  in  64*IN_W  coefficients; X[r][c] at bits [(r*8+c)*IN_W +: IN_W], r = vertical frequency, c = horizontal frequency
in_ready  out  1  core can accept a block
out_valid  out  1  out_block holds a valid reconstructed block
out_block  out  64*IN_W  samples; x[r][c] at bits [(r*8+c)*IN_W +: IN_W]
out_ready  in  1  downstream consumes the block

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state = S_IDLE, counters = 0, coefficient, intermediate and result memories all cleared to 0.
- Outputs under and after reset: out_valid = 0, out_block = 0, in_ready = 1 (in_ready is decoded from S_IDLE).
- States and transitions:
  - S_IDLE: in_ready = 1. When in_valid = 1, capture in_block into coef_mem at that edge and go to S_COL with cnt = 0.
  - S_COL: 8 cycles, cnt = 0..7. Column c = cnt is fed in as in[k] = coef_mem[k*8+c]. Results are written to tmp_mem[n*8+c]. At cnt = 7, go to S_ROW with cnt = 0.
  - S_ROW: 8 cycles. Row r = cnt is fed in as in[k] = tmp_mem[r*8+k]. Results, after the optional clamp, are written to res_mem[r*8+n]. At cnt = 7, go to S_OUT.
  - S_OUT: out_valid = 1. On out_ready = 1, return to S_IDLE.
- Timing:
  - Latency: out_valid rises 16 cycles after the accepting edge.
  - Throughput: one block per 18 cycles with out_ready tied high (1 accept + 16 compute + 1 output).
- Handshake outside S_IDLE: in_ready = 0, and in_valid and in_block are ignored.
- out_block is driven directly from res_mem. It holds the last result after the handshake and until the next block's row phase overwrites res_mem.
- out_valid and in_ready are never 1 in the same cycle.
- 1-D IDCT, direct form: out[n] = sum over k=0..7 of mul(in[k], T[k][n]).
  - mul(a,b) = (a*b computed at IN_W+CONST_W bits) >>> FRAC, truncated to IN_W.
  - The sum wraps modulo 2^IN_W.
- Basis table: T[k][n] = sign * M[(k*(2n+1)) folded].
  - M0 = 91 (k = 0 only, all n).
  - For k >= 1, magnitudes are round(128*cos(m*pi/16)) for m = 1..7: 126, 118, 106, 91, 71, 49, 25.
  - The sign follows cos(k*(2n+1)*pi/16).
  - Example: T[1][0..7] = 126, 106, 71, 25, -25, -71, -106, -126.
  - The constant table must match this list exactly.
- Intermediate tmp_mem wraps with no saturation. CLAMP acts only on the final row-pass outputs.
- Reset mid-operation (any state): abort immediately, return to the reset values, discard the partial block.
- Simultaneous in_valid with out_ready in S_OUT: in S_OUT in_ready = 0, so the new block is taken only in the following S_IDLE cycle.

Test Plan:
- DC positive: X[0][0] = 800, rest 0 -> column pass 284, all 64 outputs = 100; out_valid 16 cycles after accept.
- DC negative, checks arithmetic shift: X[0][0] = -800, rest 0 -> intermediate -285, all 64 outputs = -102.
- Single AC: X[0][1] = 256, rest 0 -> every row = 44, 37, 25, 8, -9, -26, -38, -45.
- Clamp: CLAMP = 1, X[0][0] = 2048 -> unclamped 258, all outputs = 127. Same stimulus with CLAMP = 0 -> 258.
- Backpressure: hold out_ready = 0 for 20 cycles with in_valid = 1 and a different block -> out_valid stays 1, out_block stable, in_ready = 0. Raise out_ready -> next cycle in_ready = 1, and the second block is accepted and later output correctly.
- Reset mid-S_ROW: pulse rst_n low at the 4th row cycle -> out_valid = 0, out_block = 0, in_ready = 1. A following zero block produces all-zero output after 16 cycles.
